iob_eth_driver: RTL and testbench

IOB_ETH_DRIVER -- requirements
Module: iob_eth_driver

---
 rtl/iob_eth_driver.sv | 151 +++++++++++++++
 tb/tb_iob_eth_driver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_driver.sv
// CSR access engine: turns WRITE/READ/POLL commands into IOb bus transactions
// and reports a single completion per command (read data and poll timeout).
module iob_eth_driver #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_wstrb_i,
  input  logic [DATA_W-1:0]   cmd_mask_i,
  input  logic [CNT_W-1:0]    cmd_max_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_timeout_o,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i
);

  typedef enum logic [2:0] {IDLE, REQ, RWAIT, CHECK, RESP} state_t;

  state_t                state_q;
  logic                  is_wr_q, is_poll_q;
  logic                  ready_q, valid_q, rsp_valid_q, timeout_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q, value_q, mask_q, cap_q, rdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  poll_hit;

  always_comb begin
    poll_hit = ((cap_q ^ value_q) & mask_q) == '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      is_wr_q     <= 1'b0;
      is_poll_q   <= 1'b0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      value_q     <= '0;
      mask_q      <= '0;
      cap_q       <= '0;
      rdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            is_wr_q   <= (cmd_op_i == 2'd0);
            is_poll_q <= (cmd_op_i == 2'd2);
            addr_q    <= cmd_addr_i;
            // Bus data/strobes are only meaningful for writes; reads drive zero.
            wdata_q   <= (cmd_op_i == 2'd0) ? cmd_wdata_i : '0;
            wstrb_q   <= (cmd_op_i == 2'd0) ? cmd_wstrb_i : '0;
            value_q   <= cmd_wdata_i;
            mask_q    <= cmd_mask_i;
            cnt_q     <= (cmd_max_i == '0) ? CNT_W'(1) : cmd_max_i;
            valid_q   <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (iob_ready_i) begin
            valid_q <= 1'b0;
            if (is_wr_q) begin
              rdata_q     <= '0;
              timeout_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else if (iob_rvalid_i) begin
              if (is_poll_q) begin
                cap_q   <= iob_rdata_i;
                state_q <= CHECK;
              end else begin
                rdata_q     <= iob_rdata_i;
                timeout_q   <= 1'b0;
                rsp_valid_q <= 1'b1;
                state_q     <= RESP;
              end
            end else begin
              state_q <= RWAIT;
            end
          end
        end
        RWAIT: begin
          if (iob_rvalid_i) begin
            if (is_poll_q) begin
              cap_q   <= iob_rdata_i;
              state_q <= CHECK;
            end else begin
              rdata_q     <= iob_rdata_i;
              timeout_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        CHECK: begin
          if (!poll_hit && cnt_q > CNT_W'(1)) begin
            cnt_q   <= cnt_q - CNT_W'(1);
            valid_q <= 1'b1;
            state_q <= REQ;
          end else begin
            rdata_q     <= cap_q;
            timeout_q   <= !poll_hit;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o   = ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_timeout_o = timeout_q;
  assign iob_valid_o   = valid_q;
  assign iob_addr_o    = addr_q;
  assign iob_wdata_o   = wdata_q;
  assign iob_wstrb_o   = wstrb_q;

endmodule

// File: tb/tb_iob_eth_driver.sv
// Directed bench for iob_eth_driver: command vectors against a cycle-based IOb
// slave model, plus hand-written back-to-back and mid-transaction reset checks.
module tb_iob_eth_driver;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [11:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_wstrb_i;
  logic [31:0] cmd_mask_i;
  logic [15:0] cmd_max_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_timeout_o;
  logic        iob_valid_o;
  logic [11:0] iob_addr_o;
  logic [31:0] iob_wdata_o;
  logic [3:0]  iob_wstrb_o;
  logic [31:0] iob_rdata_i;
  logic        iob_ready_i;
  logic        iob_rvalid_i;

  always #5 clk = ~clk;

  iob_eth_driver #(.ADDR_W(12), .DATA_W(32), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
    .cmd_mask_i(cmd_mask_i), .cmd_max_i(cmd_max_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_timeout_o(rsp_timeout_o),
    .iob_valid_o(iob_valid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
    .iob_wstrb_o(iob_wstrb_o), .iob_rdata_i(iob_rdata_i), .iob_ready_i(iob_ready_i),
    .iob_rvalid_i(iob_rvalid_i)
  );

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] mask;
    logic [15:0] max;
    int          rdy_wait;   // extra cycles before ready
    int          rv_wait;    // cycles after ready before rvalid
    logic [31:0] d0, d1, d2, d3;
    int          exp_reqs;
    int          exp_lat;    // cycles from accept cycle (=1) to rsp_valid cycle
    logic [31:0] exp_rdata;
    logic        exp_to;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick(input vec_t v, input int n);
    case (n)
      0:       return v.d0;
      1:       return v.d1;
      2:       return v.d2;
      default: return v.d3;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_vec(input vec_t v, input int idx);
    int lat, phase, w, nreq;
    logic done;
    logic [11:0] a;
    logic [31:0] wd;
    logic [3:0]  ws;
    string p;
    p = $sformatf("v%0d", idx);
    check({p, " ready_before"}, 64'(cmd_ready_o), 64'(1));
    cmd_op_i = v.op; cmd_addr_i = v.addr; cmd_wdata_i = v.wdata;
    cmd_wstrb_i = v.wstrb; cmd_mask_i = v.mask; cmd_max_i = v.max;
    cmd_valid_i = 1'b1;
    lat = 1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    lat = 2; phase = 0; w = 0; nreq = 0; done = 1'b0;
    a = '0; wd = '0; ws = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      iob_ready_i = 1'b0; iob_rvalid_i = 1'b0; iob_rdata_i = 32'h0BAD_0BAD;
      if (rsp_valid_o) begin
        done = 1'b1;
      end else begin
        if (phase == 2) begin
          if (iob_valid_o) check({p, " overlap"}, 64'(iob_valid_o), 64'(0));
          w++;
          if (w == v.rv_wait) begin
            iob_rvalid_i = 1'b1; iob_rdata_i = pick(v, nreq - 1); phase = 0;
          end
        end else begin
          if (phase == 0) begin
            if (iob_valid_o) begin
              nreq++;
              a = iob_addr_o; wd = iob_wdata_o; ws = iob_wstrb_o;
              check({p, " iob_addr"}, 64'(a), 64'(v.addr));
              check({p, " iob_wdata"}, 64'(wd), (v.op == 2'd0) ? 64'(v.wdata) : 64'(0));
              check({p, " iob_wstrb"}, 64'(ws), (v.op == 2'd0) ? 64'(v.wstrb) : 64'(0));
              w = 0; phase = 1;
            end
          end else begin
            w++;
            check({p, " iob_stable"}, 64'({iob_valid_o, iob_addr_o, iob_wstrb_o, iob_wdata_o}),
                  64'({1'b1, a, ws, wd}));
          end
          if (phase == 1 && w == v.rdy_wait) begin
            iob_ready_i = 1'b1;
            if (v.op == 2'd0) begin
              iob_rvalid_i = 1'b1; phase = 0;   // junk read data must be ignored
            end else if (v.rv_wait == 0) begin
              iob_rvalid_i = 1'b1; iob_rdata_i = pick(v, nreq - 1); phase = 0;
            end else begin
              phase = 2; w = 0;
            end
          end
        end
        @(negedge clk);
        lat++;
      end
    end
    iob_ready_i = 1'b0; iob_rvalid_i = 1'b0;
    check({p, " rsp_valid"}, 64'(rsp_valid_o), 64'(1));
    check({p, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({p, " num_reqs"}, 64'(nreq), 64'(v.exp_reqs));
    check({p, " rsp_rdata"}, 64'(rsp_rdata_o), 64'(v.exp_rdata));
    check({p, " rsp_timeout"}, 64'(rsp_timeout_o), 64'(v.exp_to));
    @(negedge clk);
    check({p, " rsp_pulse_end"}, 64'(rsp_valid_o), 64'(0));
    check({p, " ready_after"}, 64'(cmd_ready_o), 64'(1));
    check({p, " rdata_hold"}, 64'({rsp_timeout_o, rsp_rdata_o}), 64'({v.exp_to, v.exp_rdata}));
  endtask

  vec_t vecs[10];
  bit e_rdy[7] = '{1, 0, 0, 1, 0, 0, 1};
  bit e_val[7] = '{0, 1, 0, 0, 1, 0, 0};
  bit e_rsp[7] = '{0, 0, 1, 0, 0, 1, 0};

  initial begin
    vecs[0] = '{op:2'd0, addr:12'h004, wdata:32'hDEADBEEF, wstrb:4'hF, mask:32'h0, max:16'd0,
                rdy_wait:0, rv_wait:0, d0:32'h0, d1:32'h0, d2:32'h0, d3:32'h0,
                exp_reqs:1, exp_lat:3, exp_rdata:32'h0, exp_to:1'b0};
    vecs[1] = '{op:2'd1, addr:12'h010, wdata:32'h0, wstrb:4'h0, mask:32'h0, max:16'd0,
                rdy_wait:4, rv_wait:2, d0:32'h12345678, d1:32'h0, d2:32'h0, d3:32'h0,
                exp_reqs:1, exp_lat:9, exp_rdata:32'h12345678, exp_to:1'b0};
    vecs[2] = '{op:2'd2, addr:12'h008, wdata:32'h1, wstrb:4'hF, mask:32'h1, max:16'd5,
                rdy_wait:0, rv_wait:0, d0:32'h0, d1:32'h0, d2:32'h1, d3:32'h1,
                exp_reqs:3, exp_lat:8, exp_rdata:32'h1, exp_to:1'b0};
    vecs[3] = '{op:2'd2, addr:12'h00C, wdata:32'hAA, wstrb:4'h0, mask:32'hFF, max:16'd4,
                rdy_wait:0, rv_wait:0, d0:32'h55, d1:32'h55, d2:32'h55, d3:32'h55,
                exp_reqs:4, exp_lat:10, exp_rdata:32'h55, exp_to:1'b1};
    vecs[4] = '{op:2'd0, addr:12'h020, wdata:32'hCAFEF00D, wstrb:4'h3, mask:32'h0, max:16'd0,
                rdy_wait:2, rv_wait:0, d0:32'h0, d1:32'h0, d2:32'h0, d3:32'h0,
                exp_reqs:1, exp_lat:5, exp_rdata:32'h0, exp_to:1'b0};
    vecs[5] = '{op:2'd3, addr:12'h030, wdata:32'h0, wstrb:4'hF, mask:32'h0, max:16'd0,
                rdy_wait:0, rv_wait:0, d0:32'hA5A55A5A, d1:32'h0, d2:32'h0, d3:32'h0,
                exp_reqs:1, exp_lat:3, exp_rdata:32'hA5A55A5A, exp_to:1'b0};
    vecs[6] = '{op:2'd2, addr:12'h040, wdata:32'h1, wstrb:4'h0, mask:32'h1, max:16'd0,
                rdy_wait:0, rv_wait:0, d0:32'h0, d1:32'h0, d2:32'h0, d3:32'h0,
                exp_reqs:1, exp_lat:4, exp_rdata:32'h0, exp_to:1'b1};
    vecs[7] = '{op:2'd2, addr:12'h044, wdata:32'hFFFFFFFF, wstrb:4'h0, mask:32'h1, max:16'd3,
                rdy_wait:0, rv_wait:0, d0:32'hF0F00001, d1:32'h0, d2:32'h0, d3:32'h0,
                exp_reqs:1, exp_lat:4, exp_rdata:32'hF0F00001, exp_to:1'b0};
    vecs[8] = '{op:2'd2, addr:12'h048, wdata:32'h1, wstrb:4'h0, mask:32'h1, max:16'd2,
                rdy_wait:1, rv_wait:1, d0:32'h2, d1:32'h4, d2:32'h0, d3:32'h0,
                exp_reqs:2, exp_lat:10, exp_rdata:32'h4, exp_to:1'b1};
    vecs[9] = '{op:2'd1, addr:12'hFFC, wdata:32'h0, wstrb:4'h0, mask:32'h0, max:16'd0,
                rdy_wait:0, rv_wait:3, d0:32'hBEEF0001, d1:32'h0, d2:32'h0, d3:32'h0,
                exp_reqs:1, exp_lat:6, exp_rdata:32'hBEEF0001, exp_to:1'b0};

    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_addr_i = '0; cmd_wdata_i = '0;
    cmd_wstrb_i = '0; cmd_mask_i = '0; cmd_max_i = '0;
    iob_rdata_i = '0; iob_ready_i = 1'b0; iob_rvalid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;

    check("reset cmd_ready", 64'(cmd_ready_o), 64'(1));
    check("reset iob_valid", 64'(iob_valid_o), 64'(0));
    check("reset rsp", 64'({rsp_valid_o, rsp_timeout_o, rsp_rdata_o}), 64'(0));
    check("reset iob_bus", 64'({iob_addr_o, iob_wstrb_o, iob_wdata_o}), 64'(0));

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Back-to-back: second command held while busy, taken only once idle.
    iob_ready_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      check($sformatf("b2b%0d cmd_ready", k), 64'(cmd_ready_o), 64'(e_rdy[k]));
      check($sformatf("b2b%0d iob_valid", k), 64'(iob_valid_o), 64'(e_val[k]));
      check($sformatf("b2b%0d rsp_valid", k), 64'(rsp_valid_o), 64'(e_rsp[k]));
      if (k == 1) check("b2b first addr", 64'(iob_addr_o), 64'(12'h100));
      if (k == 4) check("b2b second addr", 64'(iob_addr_o), 64'(12'h104));
      if (k == 0) begin
        cmd_valid_i = 1'b1; cmd_op_i = 2'd0; cmd_addr_i = 12'h100;
        cmd_wdata_i = 32'h11111111; cmd_wstrb_i = 4'hF;
      end
      if (k == 1) begin
        cmd_addr_i = 12'h104; cmd_wdata_i = 32'h22222222;
      end
      if (k == 4) cmd_valid_i = 1'b0;
      @(negedge clk);
    end
    iob_ready_i = 1'b0;

    // Reset while waiting for read data abandons the read silently.
    cmd_op_i = 2'd1; cmd_addr_i = 12'h010; cmd_valid_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    check("rst iob_valid_req", 64'(iob_valid_o), 64'(1));
    iob_ready_i = 1'b1;
    @(negedge clk);
    iob_ready_i = 1'b0;
    check("rst in_rwait", 64'({cmd_ready_o, iob_valid_o, rsp_valid_o}), 64'(0));
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("rst cmd_ready", 64'(cmd_ready_o), 64'(1));
    check("rst iob_valid", 64'(iob_valid_o), 64'(0));
    check("rst rsp_cleared", 64'({rsp_valid_o, rsp_timeout_o, rsp_rdata_o}), 64'(0));
    iob_rvalid_i = 1'b1; iob_ready_i = 1'b1; iob_rdata_i = 32'h00000777;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("late%0d idle", k),
            64'({cmd_ready_o, iob_valid_o, rsp_valid_o, rsp_rdata_o}), 64'({3'b100, 32'h0}));
    end
    iob_rvalid_i = 1'b0; iob_ready_i = 1'b0;

    run_vec(vecs[1], 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
